fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx_pkg.sv | 26 ++
 rtl/baud_tick_gen.sv | 43 ++++
 rtl/fifo_uart_tx.sv | 118 +++++++++++
 tb/tb_fifo_uart_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART definitions: FSM encoding, frame constants and baud arithmetic.
// The future UART RX imports this package as well.
package fifo_uart_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   // Clocks per bit; integer division, so the real baud rate is slightly fast
   // when CLK_FREQ is not an exact multiple of BAUD_RATE.
   function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   // Width of a counter spanning 0..baud_div-1 (never narrower than one bit).
   function automatic int calc_cnt_width(input int baud_div);
      return (baud_div > 1) ? $clog2(baud_div) : 1;
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..BAUD_DIV-1 while enabled and flags the last
// cycle of each bit period. Shared by the UART TX and the future RX.
module baud_tick_gen
   import fifo_uart_tx_pkg::*;
#(
   parameter int BAUD_DIV = 2   // clocks per bit, must be >= 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int             CNT_W    = calc_cnt_width(BAUD_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins, otherwise advance and wrap at the bit boundary.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no latch is inferred.
      cnt_d = cnt_q;
      tick  = enable && (cnt_q == CNT_LAST);
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART 8N1 transmitter. Pops the show-ahead FIFO head whenever the
// line is idle or a stop bit is ending, so frames run back-to-back with no gap.
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD_RATE = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_rdata,
   output logic       fifo_pop,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int       BAUD_DIV  = calc_baud_div(CLK_FREQ, BAUD_RATE);
   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

   tx_state_e  state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic       tx_q, tx_d;
   logic       bit_tick;
   logic       last_stop;
   logic       cnt_clear;
   logic       cnt_en;

   // Counter restarts on every pop so bit timing aligns with the frame load,
   // and sits at zero while the line is idle.
   assign cnt_en    = (state_q != IDLE);
   assign cnt_clear = fifo_pop || (state_q == IDLE);

   baud_tick_gen #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud_tick_gen (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .tick   (bit_tick)
   );

   // FSM next state, pop/done strobes, shift register and next tx level.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;

      last_stop = (state_q == STOP) && bit_tick && (bit_idx_q == LAST_STOP);
      fifo_pop  = ((state_q == IDLE) || last_stop) && !fifo_empty && !rst;
      tx_done   = last_stop && !rst;

      case (state_q)
         IDLE: begin
            if (fifo_pop) state_d = START;
         end
         START: begin
            if (bit_tick) state_d = DATA;
         end
         DATA: begin
            if (bit_tick) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == LAST_DATA) begin
                  bit_idx_d = '0;
                  state_d   = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (bit_tick) begin
               if (bit_idx_q == LAST_STOP) begin
                  bit_idx_d = '0;
                  state_d   = fifo_pop ? START : IDLE;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // The head byte is captured on the pop edge; later rdata changes are ignored.
      if (fifo_pop) shift_d = fifo_rdata;

      // tx is registered from the next state so the line lines up with it.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   // State, shift register, bit index and line register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         // NOTE: the shift register is plain flops, not a memory, so it is reset with the rest of the datapath.
         shift_q   <= '0;
         bit_idx_q <= '0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
      end
   end

   assign tx      = tx_q;
   assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: vector table, directed corner-case
// sequences and a randomized run against a frame-position reference model.
module tb_fifo_uart_tx;

   localparam int CLK_FREQ  = 1_000_000;
   localparam int BAUD_RATE = 100_000;
   localparam int D         = CLK_FREQ / BAUD_RATE;   // clocks per bit
   localparam int FL        = 10 * D;                 // clocks per frame

   logic       clk        = 1'b0;
   logic       rst        = 1'b1;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_rdata = 8'h00;
   logic       fifo_pop;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;

   always #5 clk = ~clk;

   fifo_uart_tx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_pop   (fifo_pop),
      .tx         (tx),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: position inside the current frame (-1 when idle).
   int         m_pos  = -1;
   logic [7:0] m_byte = 8'h00;

   logic tx_hist[$];
   int   pop_cyc[$];
   int   done_cyc[$];
   int   busy_cnt = 0;
   logic [3:0] obs;   // {fifo_pop, tx, tx_busy, tx_done} of the last cycle

   typedef struct {
      logic       r;
      logic       e;
      logic [7:0] d;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs[6];

   // Line level at a given frame position: start 0, data LSB first, stop 1.
   function automatic logic frame_bit(input int p, input logic [7:0] b);
      int k;
      if (p < 0) return 1'b1;
      k = p / D;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      return 1'b1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: drive inputs after the edge, sample mid-cycle, compare to model.
   task automatic step(input logic r, input logic e, input logic [7:0] d);
      logic       e_pop;
      logic [3:0] exp_v;
      @(posedge clk);
      #1;
      rst        = r;
      fifo_empty = e;
      fifo_rdata = d;
      @(negedge clk);
      e_pop = ((m_pos < 0) || (m_pos == FL - 1)) && !e && !r;
      exp_v = {e_pop, frame_bit(m_pos, m_byte), (m_pos >= 0), (m_pos == FL - 1) && !r};
      obs   = {fifo_pop, tx, tx_busy, tx_done};
      check($sformatf("model cycle %0d", cyc), 32'(obs), 32'(exp_v));
      tx_hist.push_back(tx);
      if (fifo_pop) pop_cyc.push_back(cyc);
      if (tx_done)  done_cyc.push_back(cyc);
      if (tx_busy)  busy_cnt++;
      if (r)                  m_pos = -1;
      else if (e_pop)         begin m_pos = 0; m_byte = d; end
      else if (m_pos == FL-1) m_pos = -1;
      else if (m_pos >= 0)    m_pos++;
      cyc++;
   endtask

   task automatic idle(input int n, input logic [7:0] junk);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, junk);
   endtask

   // Hold fifo_empty low with byte b until a pop is seen (bounded).
   task automatic push_byte(input logic [7:0] b, output int p);
      int n0;
      int k;
      n0 = pop_cyc.size();
      k  = 0;
      while (pop_cyc.size() == n0 && k < 3 * FL) begin
         step(1'b0, 1'b0, b);
         k++;
      end
      check("pop within budget", pop_cyc.size() - n0, 1);
      p = (pop_cyc.size() > n0) ? pop_cyc[n0] : 0;
   endtask

   // Decode a frame from recorded tx levels, sampling each bit at its centre.
   function automatic logic [7:0] decode(input int s);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[i] = tx_hist[s + (i + 1) * D + D / 2];
      return b;
   endfunction

   task automatic check_frame(input string name, input int s, input logic [7:0] b);
      check({name, " start bit"}, 32'(tx_hist[s + D / 2]), 0);
      check({name, " data"}, 32'(decode(s)), 32'(b));
      check({name, " stop bit"}, 32'(tx_hist[s + 9 * D + D / 2]), 1);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int p, p2, s, n0, d0, b0, npop;

      // Reset for two cycles, then 50 quiet cycles.
      step(1'b1, 1'b1, 8'h00);
      step(1'b1, 1'b1, 8'h00);
      idle(50, 8'h00);
      check("idle pops", pop_cyc.size(), 0);
      check("idle dones", done_cyc.size(), 0);
      check("idle busy", busy_cnt, 0);

      // Vector table: {rst, empty, rdata} -> {pop, tx, busy, done}.
      vecs[0] = '{r: 1'b1, e: 1'b0, d: 8'hA5, exp: 4'b0100};  // no pop in reset
      vecs[1] = '{r: 1'b0, e: 1'b1, d: 8'h00, exp: 4'b0100};
      vecs[2] = '{r: 1'b0, e: 1'b0, d: 8'hA5, exp: 4'b1100};  // pop 0xA5
      vecs[3] = '{r: 1'b0, e: 1'b1, d: 8'h5A, exp: 4'b0010};  // start bit
      vecs[4] = '{r: 1'b0, e: 1'b0, d: 8'h3C, exp: 4'b0010};  // no mid-frame pop
      vecs[5] = '{r: 1'b0, e: 1'b1, d: 8'h00, exp: 4'b0010};
      for (int i = 0; i < 6; i++) begin
         step(vecs[i].r, vecs[i].e, vecs[i].d);
         check($sformatf("vec %0d", i), 32'(obs), 32'(vecs[i].exp));
      end
      idle(FL, 8'hFF);
      p = (pop_cyc.size() > 0) ? pop_cyc[0] : 0;
      check_frame("A5", p + 1, 8'hA5);
      check("A5 pops", pop_cyc.size(), 1);
      check("A5 dones", done_cyc.size(), 1);
      check("A5 done cycle", (done_cyc.size() > 0) ? done_cyc[0] : -1, p + FL);
      check("A5 busy cycles", busy_cnt, FL);

      // Back-to-back 0x00 then 0xFF.
      n0 = pop_cyc.size();
      d0 = done_cyc.size();
      b0 = busy_cnt;
      for (int k = 0; k < 3 * FL; k++) begin
         npop = pop_cyc.size() - n0;
         if (npop >= 2) break;
         step(1'b0, 1'b0, (npop == 0) ? 8'h00 : 8'hFF);
      end
      idle(FL + 5, 8'h55);
      check("b2b pops", pop_cyc.size() - n0, 2);
      check("b2b dones", done_cyc.size() - d0, 2);
      check("b2b pop on done", pop_cyc[n0 + 1], done_cyc[d0]);
      check("b2b busy cycles", busy_cnt - b0, 2 * FL);
      check_frame("b2b 00", pop_cyc[n0] + 1, 8'h00);
      check_frame("b2b FF", pop_cyc[n0 + 1] + 1, 8'hFF);

      // rdata changes right after the pop.
      push_byte(8'h5A, p);
      idle(FL + 5, 8'h3C);
      check_frame("5A", p + 1, 8'h5A);

      // Reset during data bit 3, then an immediate fresh pop.
      push_byte(8'hC3, p);
      s = p + 1;
      while (cyc < s + 4 * D + D / 2) step(1'b0, 1'b1, 8'h00);
      d0 = done_cyc.size();
      step(1'b1, 1'b0, 8'h96);
      step(1'b0, 1'b0, 8'h96);
      check("after reset pop/idle line", 32'(obs), 32'(4'b1100));
      p2 = cyc - 1;
      check("after reset pop cycle", pop_cyc[pop_cyc.size() - 1], p2);
      idle(FL + 5, 8'h00);
      check("reset dones", done_cyc.size() - d0, 1);
      check_frame("96", p2 + 1, 8'h96);

      // FIFO goes non-empty during bit 5: pop waits for the last stop cycle.
      push_byte(8'h33, p);
      s = p + 1;
      while (cyc < s + 6 * D + D / 2) step(1'b0, 1'b1, 8'h00);
      push_byte(8'hE7, p2);
      check("late pop cycle", p2, p + FL);
      check("late pop on done", done_cyc[done_cyc.size() - 1], p2);
      idle(FL + 5, 8'h00);
      check_frame("33", s, 8'h33);
      check_frame("E7", p2 + 1, 8'hE7);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) != 0), 8'($urandom));
      end
      idle(FL + 5, 8'h00);
      check("final line idle", 32'(obs), 32'(4'b0100));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
